scan_controller: RTL

Control FSM sitting directly upstream of the memory occupancy counter. It drives that counter's `scan` and `flush` strobes and reads back its `mem_used` value. It sequences a scanner through low-power, idle, scanning and flushing phases, paces scan pulses, and flags when enough data is buffered to transfer. It also powers down after a quiet period with an empty buffer.

---
 rtl/scanner_pkg.sv | 26 ++
 rtl/cycle_timer.sv | 49 ++++
 rtl/scan_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/scanner_pkg.sv
// scanner_pkg
// Shared types and constants for the scanner control path. The memory
// occupancy counter uses the same FULL/XFER defaults, so it imports this package too.
//   state_t              : controller state encoding (also exported on the debug port)
//   FULL_DEFAULT         : occupancy ceiling of the memory counter
//   XFER_THRESH_DEFAULT  : occupancy at which a transfer is offered
//   cnt_width()          : counter width for a given modulus, never less than 1 bit

package scanner_pkg;

  typedef enum logic [1:0] {
    LOW_POWER = 2'd0,
    IDLE      = 2'd1,
    SCANNING  = 2'd2,
    FLUSHING  = 2'd3
  } state_t;

  localparam int unsigned FULL_DEFAULT        = 100;
  localparam int unsigned XFER_THRESH_DEFAULT = 80;

  // $clog2(1) is 0, and a zero-width counter is not legal.
  function automatic int unsigned cnt_width(int unsigned modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer
// Modulo-MOD cycle counter with a synchronous clear. Clear has priority over
// enable. The counter wraps from MOD-1 to 0.
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset, sets the count to 0
//   clr      : synchronous clear to 0
//   en       : advance the count by one this cycle
//   terminal : count == MOD-1
//   zero     : count == 0

module cycle_timer
  import scanner_pkg::*;
#(
  parameter int unsigned MOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic terminal,
  output logic zero
);

  localparam int unsigned W = cnt_width(MOD);
  localparam logic [W-1:0] Last = W'(MOD - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == Last) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == Last);
  assign zero     = (count_q == '0);

endmodule

// File: rtl/scan_controller.sv
// scan_controller
// Control FSM sitting directly upstream of the memory occupancy counter. It sequences the scanner
// through LOW_POWER, IDLE, SCANNING and FLUSHING, paces scan pulses every SCAN_PERIOD cycles, and
// offers a transfer once occupancy reaches XFER_THRESH. It drops to LOW_POWER after IDLE_TIMEOUT
// quiet cycles with an empty buffer.
//   clk               : clock, rising edge
//   reset             : synchronous active-high reset, enters LOW_POWER
//   start             : level, request to begin scanning
//   stop              : level, abort scanning
//   flush_req         : level, downstream grants a transfer
//   mem_used          : occupancy reported by the memory counter (unsigned)
//   scan              : increment strobe to the memory counter
//   flush             : drain strobe to the memory counter
//   ready_to_transfer : occupancy at or above XFER_THRESH while idle or scanning
//   low_power         : controller is in LOW_POWER
//   done              : one-cycle pulse on the last FLUSHING cycle
//   state             : current state encoding, for debug
// Outputs are combinational from the registered state and the current inputs. The counter sees the
// strobes one edge later, so scan is gated on the live occupancy to stop at the ceiling.

module scan_controller
  import scanner_pkg::*;
#(
  parameter int unsigned FULL         = FULL_DEFAULT,
  parameter int unsigned XFER_THRESH  = XFER_THRESH_DEFAULT,
  parameter int unsigned SCAN_PERIOD  = 1,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       flush_req,
  input  logic [7:0] mem_used,
  output logic       scan,
  output logic       flush,
  output logic       ready_to_transfer,
  output logic       low_power,
  output logic       done,
  output logic [1:0] state
);

  localparam logic [7:0] FullLvl = 8'(FULL);
  localparam logic [7:0] XferLvl = 8'(XFER_THRESH);

  state_t state_q, state_d;

  logic below_full;
  logic at_xfer;
  logic nonempty;
  logic xfer_grant;
  logic quiet;
  logic idle_term, idle_zero;
  logic phase_term, phase_zero;
  logic idle_timeout;
  logic unused_timer_flags;

  assign below_full = (mem_used < FullLvl);
  assign at_xfer    = (mem_used >= XferLvl);
  assign nonempty   = (mem_used != 8'd0);
  assign xfer_grant = flush_req & at_xfer;

  // Any activity or a non-empty buffer restarts the power-down countdown.
  assign quiet = ~nonempty & ~start & ~flush_req;

  // The idle timer is held clear outside IDLE, so it reads 0 on the first IDLE cycle.
  cycle_timer #(
    .MOD (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      ((state_q != IDLE) | ~quiet),
    .en       (state_q == IDLE),
    .terminal (idle_term),
    .zero     (idle_zero)
  );

  // The phase counter is held clear outside SCANNING, so the first SCANNING cycle is phase 0.
  cycle_timer #(
    .MOD (SCAN_PERIOD)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q != SCANNING),
    .en       (state_q == SCANNING),
    .terminal (phase_term),
    .zero     (phase_zero)
  );

  // Timer flags not needed here.
  assign unused_timer_flags = idle_zero ^ phase_term;

  // The count reaches IDLE_TIMEOUT-1 on the last quiet cycle, so IDLE lasts exactly IDLE_TIMEOUT.
  assign idle_timeout = idle_term & quiet;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOW_POWER: begin
        if (start) begin
          state_d = SCANNING;
        end
      end
      IDLE: begin
        if (start && below_full) begin
          state_d = SCANNING;
        end else if (flush_req && nonempty) begin
          state_d = FLUSHING;
        end else if (idle_timeout) begin
          state_d = LOW_POWER;
        end
      end
      SCANNING: begin
        if (stop) begin
          state_d = IDLE;
        end else if (xfer_grant) begin
          state_d = FLUSHING;
        end else if (!below_full) begin
          state_d = IDLE;
        end
      end
      FLUSHING: begin
        // Requests are ignored until the drain completes.
        if (!nonempty) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOW_POWER;
    end else begin
      state_q <= state_d;
    end
  end

  // Suppress the pulse on any cycle where SCANNING is about to be left.
  assign scan = (state_q == SCANNING) & phase_zero & below_full & ~stop & ~xfer_grant;
  assign flush = (state_q == FLUSHING) & nonempty;
  assign ready_to_transfer = ((state_q == IDLE) | (state_q == SCANNING)) & at_xfer;
  assign low_power = (state_q == LOW_POWER);
  assign done = (state_q == FLUSHING) & ~nonempty;
  assign state = state_q;

  // The memory counter cannot take both strobes in one cycle.
  assert property (@(posedge clk) !(scan && flush));

endmodule
